// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a status-less LIFO: tracks occupancy,
// rejects overflow/underflow, returns pop data and drains the stack on flush.
// Optional build macro STACK_ARB_STATS_EN adds saturating overflow/underflow counters.
module stack_arbiter #(
    parameter int WIDTH = 18,
    parameter int SIZE  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_op,
    input  logic [2*WIDTH-1:0] req_data,
    output logic [1:0]         req_ready,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    input  logic               flush,
    output logic               busy,
    output logic               flush_done,
    output logic [SIZE:0]      count,
    output logic               full,
    output logic               empty,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [WIDTH-1:0]   stk_data_in,
    input  logic [WIDTH-1:0]   stk_data_out
`ifdef STACK_ARB_STATS_EN
    ,
    output logic [15:0]        ovf_cnt,
    output logic [15:0]        unf_cnt
`endif
);

    localparam logic [SIZE:0] C_DEPTH = (SIZE+1)'(2**SIZE);
    localparam logic [SIZE:0] C_ONE   = (SIZE+1)'(1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic [SIZE:0]    r_count;
    logic [1:0]       r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic             r_flush_done;

    logic             w_grant;
    logic             w_win;
    logic             w_op;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_reject;
    logic             w_push_rej;
    logic             w_pop_rej;
    logic             w_flush_fin;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush is only sampled in RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (flush && !w_empty) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_count <= C_ONE) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Output logic: arbitration, stack strobes and flush drain.
    // Grants are also gated by reset so the stack sees no strobe while held in reset.
    always_comb begin
        w_grant     = 1'b0;
        w_win       = 1'b0;
        w_op        = 1'b0;
        w_push_ok   = 1'b0;
        w_pop_ok    = 1'b0;
        w_push_rej  = 1'b0;
        w_pop_rej   = 1'b0;
        w_flush_fin = 1'b0;
        req_ready   = 2'b00;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        busy        = 1'b0;
        case (r_state)
            S_RUN: begin
                if (flush) begin
                    w_flush_fin = w_empty;
                end else if (reset && (req_valid != 2'b00)) begin
                    w_grant = 1'b1;
                    w_win   = (&req_valid) ? r_rr_ptr : req_valid[1];
                    w_op    = w_win ? req_op[1] : req_op[0];
                    req_ready = w_win ? 2'b10 : 2'b01;
                    if (!w_op) begin
                        w_push_ok  = !w_full;
                        w_push_rej = w_full;
                    end else begin
                        w_pop_ok  = !w_empty;
                        w_pop_rej = w_empty;
                    end
                end
                stk_push = w_push_ok;
                stk_pop  = w_pop_ok;
                if (w_push_ok) begin
                    stk_data_in = w_win ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
                end
            end
            S_FLUSH: begin
                busy        = 1'b1;
                stk_pop     = !w_empty;
                w_flush_fin = (r_count == C_ONE);
            end
            default: ;
        endcase
    end

    assign w_reject = w_push_rej | w_pop_rej;

    // Occupancy follows the stack strobes exactly, so count and the stack pointer stay in step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_rr_ptr     <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            if (stk_push) begin
                r_count <= r_count + C_ONE;
            end else if (stk_pop) begin
                r_count <= r_count - C_ONE;
            end
            if (w_grant) begin
                r_rr_ptr <= ~w_win;
            end
            r_rsp_valid  <= req_ready;
            r_rsp_err    <= w_reject;
            r_rsp_data   <= w_pop_ok ? stk_data_out : '0;
            r_flush_done <= w_flush_fin;
        end
    end

`ifdef STACK_ARB_STATS_EN
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_unf_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else begin
            if (w_push_rej) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
            if (w_pop_rej) begin
                r_unf_cnt <= sat_inc(r_unf_cnt);
            end
        end
    end

    assign ovf_cnt = r_ovf_cnt;
    assign unf_cnt = r_unf_cnt;
`endif

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign flush_done = r_flush_done;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter (WIDTH=18, SIZE=2) with an attached behavioural LIFO:
// directed vector table, hand-written flush/reset sequences, and random traffic vs a queue model.
module tb_stack_arbiter;

    localparam int W = 18;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_op;
    logic [2*W-1:0] req_data;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           flush;
    logic           busy;
    logic           flush_done;
    logic [S:0]     count;
    logic           full;
    logic           empty;
    logic           stk_push;
    logic           stk_pop;
    logic [W-1:0]   stk_data_in;
    logic [W-1:0]   stk_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.WIDTH(W), .SIZE(S)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush), .busy(busy), .flush_done(flush_done),
        .count(count), .full(full), .empty(empty),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out)
    );

    // Attached LIFO: push writes at sp, pop decrements sp, top-of-stack is combinational
    logic [W-1:0] mem [4];
    logic [2:0]   sp;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= 3'd0;
        end else if (stk_push) begin
            mem[sp[1:0]] <= stk_data_in;
            sp <= sp + 3'd1;
        end else if (stk_pop) begin
            sp <= sp - 3'd1;
        end
    end
    assign stk_data_out = (sp == 3'd0) ? '0 : mem[2'(sp - 3'd1)];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = 2'b00;
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push0(input logic [W-1:0] d);
        @(negedge clk);
        req_valid = 2'b01;
        req_op = 2'b00;
        req_data = {{W{1'b0}}, d};
        @(posedge clk);
        #1;
        req_valid = 2'b00;
    endtask

    typedef struct {
        logic         rst;
        logic [1:0]   vld;
        logic [1:0]   op;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [1:0]   e_rdy;
        logic         e_push;
        logic         e_pop;
        logic [1:0]   e_rv;
        logic         e_err;
        logic [W-1:0] e_rd;
        logic [S:0]   e_cnt;
    } vec_t;

    vec_t tbl[12];

    logic [W-1:0] q[$];
    int           prio;
    int           flush_left;

    initial begin
        reset = 1'b0;
        req_valid = 2'b00;
        req_op = 2'b00;
        req_data = '0;
        flush = 1'b0;

        tbl[0]  = '{1'b1, 2'b01, 2'b00, 18'h15555, 18'h0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 18'h0,     3'd1};
        tbl[1]  = '{1'b0, 2'b01, 2'b01, 18'h0,     18'h0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 18'h15555, 3'd0};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 18'h1,     18'h2, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 18'h0,     3'd1};
        tbl[3]  = '{1'b0, 2'b11, 2'b00, 18'h1,     18'h2, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 18'h0,     3'd2};
        tbl[4]  = '{1'b0, 2'b11, 2'b00, 18'h1,     18'h2, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 18'h0,     3'd3};
        tbl[5]  = '{1'b0, 2'b11, 2'b00, 18'h1,     18'h2, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 18'h0,     3'd4};
        tbl[6]  = '{1'b0, 2'b11, 2'b00, 18'h1,     18'h2, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 18'h0,     3'd4};
        tbl[7]  = '{1'b0, 2'b11, 2'b11, 18'h0,     18'h0, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 18'h2,     3'd3};
        tbl[8]  = '{1'b0, 2'b11, 2'b11, 18'h0,     18'h0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 18'h1,     3'd2};
        tbl[9]  = '{1'b0, 2'b11, 2'b11, 18'h0,     18'h0, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 18'h2,     3'd1};
        tbl[10] = '{1'b0, 2'b11, 2'b11, 18'h0,     18'h0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 18'h1,     3'd0};
        tbl[11] = '{1'b0, 2'b01, 2'b01, 18'h0,     18'h0, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 18'h0,     3'd0};

        // Reset state
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_stk_push", 32'(stk_push), 32'd0);
        chk("rst_stk_pop", 32'(stk_pop), 32'd0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            @(negedge clk);
            req_valid = tbl[i].vld;
            req_op = tbl[i].op;
            req_data = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_stk_push", i), 32'(stk_push), 32'(tbl[i].e_push));
            chk($sformatf("v%0d_stk_pop", i), 32'(stk_pop), 32'(tbl[i].e_pop));
            if (tbl[i].e_push)
                chk($sformatf("v%0d_stk_din", i), 32'(stk_data_in),
                    32'(tbl[i].e_rdy[1] ? tbl[i].d1 : tbl[i].d0));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_cnt == 3'd4));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 3'd0));
        end
        @(negedge clk);
        req_valid = 2'b00;

        // Flush of three entries
        begin
            int nb, np, nr, nd;
            nb = 0; np = 0; nr = 0; nd = 0;
            do_reset();
            push0(18'h00A);
            push0(18'h00B);
            push0(18'h00C);
            chk("fl_pre_count", 32'(count), 32'd3);
            @(negedge clk);
            flush = 1'b1;
            #1;
            chk("fl_entry_pop", 32'(stk_pop), 32'd0);
            chk("fl_entry_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk("fl_busy_after_entry", 32'(busy), 32'd1);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                flush = 1'b0;
                if (busy) begin
                    req_valid = 2'b11;
                    req_op = 2'b00;
                end else begin
                    req_valid = 2'b00;
                end
                #1;
                if (busy) begin
                    nb++;
                    if (req_ready != 2'b00) nr++;
                end
                if (stk_pop) np++;
                @(posedge clk);
                #1;
                if (flush_done) begin
                    nd++;
                    chk("fl_done_count", 32'(count), 32'd0);
                    chk("fl_done_empty", 32'(empty), 32'd1);
                end
            end
            req_valid = 2'b00;
            chk("fl_busy_cycles", 32'(nb), 32'd3);
            chk("fl_pop_cycles", 32'(np), 32'd3);
            chk("fl_ready_while_busy", 32'(nr), 32'd0);
            chk("fl_done_pulses", 32'(nd), 32'd1);
        end

        // Flush when already empty
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fe_pop", 32'(stk_pop), 32'd0);
        chk("fe_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("fe_done", 32'(flush_done), 32'd1);
        chk("fe_busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("fe_done_clear", 32'(flush_done), 32'd0);
        chk("fe_count", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a flush
        do_reset();
        push0(18'h001);
        push0(18'h002);
        push0(18'h003);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_count_mid", 32'(count), 32'd2);
        chk("mr_busy_mid", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_stk_pop", 32'(stk_pop), 32'd0);
        chk("mr_stk_push", 32'(stk_push), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_flush_done", 32'(flush_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b11;
        req_op = 2'b00;
        req_data = {18'h0BBBB, 18'h0AAAA};
        #1;
        chk("mr_first_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mr_first_rsp", 32'(rsp_valid), 32'd1);
        chk("mr_first_count", 32'(count), 32'd1);
        req_valid = 2'b00;

        // Random traffic against a queue-based reference model
        do_reset();
        q.delete();
        prio = 0;
        flush_left = 0;
        for (int c = 0; c < 600; c++) begin
            logic [1:0]   vld, op, e_rdy, n_rv;
            logic [W-1:0] d0, d1, n_rd;
            logic         fl, e_push, e_pop, e_busy, n_err, n_fd;
            int           w;
            vld = 2'($urandom_range(0, 3));
            op  = 2'($urandom_range(0, 3));
            d0  = W'($urandom);
            d1  = W'($urandom);
            fl  = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            req_valid = vld;
            req_op = op;
            req_data = {d1, d0};
            flush = fl;

            e_rdy = 2'b00; e_push = 1'b0; e_pop = 1'b0; n_rv = 2'b00;
            n_err = 1'b0; n_rd = '0; n_fd = 1'b0;
            e_busy = (flush_left > 0);
            if (flush_left > 0) begin
                e_pop = 1'b1;
                void'(q.pop_back());
                flush_left--;
                if (flush_left == 0) n_fd = 1'b1;
            end else if (fl) begin
                if (q.size() == 0) n_fd = 1'b1;
                else flush_left = q.size();
            end else if (vld != 2'b00) begin
                w = (vld == 2'b11) ? prio : ((vld == 2'b10) ? 1 : 0);
                prio = 1 - w;
                e_rdy = (w == 1) ? 2'b10 : 2'b01;
                n_rv = e_rdy;
                if (op[w] == 1'b0) begin
                    if (q.size() < 4) begin
                        e_push = 1'b1;
                        q.push_back((w == 1) ? d1 : d0);
                    end else begin
                        n_err = 1'b1;
                    end
                end else begin
                    if (q.size() > 0) begin
                        e_pop = 1'b1;
                        n_rd = q.pop_back();
                    end else begin
                        n_err = 1'b1;
                    end
                end
            end

            #1;
            chk("rnd_ready", 32'(req_ready), 32'(e_rdy));
            chk("rnd_stk_push", 32'(stk_push), 32'(e_push));
            chk("rnd_stk_pop", 32'(stk_pop), 32'(e_pop));
            chk("rnd_busy", 32'(busy), 32'(e_busy));
            if (e_push)
                chk("rnd_stk_din", 32'(stk_data_in), 32'(q[q.size()-1]));
            @(posedge clk);
            #1;
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(n_rv));
            chk("rnd_rsp_err", 32'(rsp_err), 32'(n_err));
            chk("rnd_rsp_data", 32'(rsp_data), 32'(n_rd));
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_full", 32'(full), 32'(q.size() == 4));
            chk("rnd_empty", 32'(empty), 32'(q.size() == 0));
            chk("rnd_flush_done", 32'(flush_done), 32'(n_fd));
        end
        req_valid = 2'b00;
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one `stack` instance (WIDTH/SIZE LIFO; push/pop act on the clock edge; data_out is combinational top-of-stack) between two requesters.
- Round-robin arbitration, one stack operation per cycle.
- The stack has no status flags, so this block tracks occupancy, guards against overflow/underflow, and returns pop data to the winning requester.
- Also provides a flush sequence that drains the stack on command.

Parameters:
- WIDTH, 18, data width; must match the attached stack.
- SIZE, 1, stack address bits; depth DEPTH = 2**SIZE; must match the attached stack.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  2  per-requester request valid.
- req_op  in  2  per-requester op: 0 = push, 1 = pop.
- req_data  in  2*WIDTH  push data; requester r occupies bits [r*WIDTH +: WIDTH].
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- rsp_valid  out  2  one-cycle response pulse to the requester accepted in the previous cycle.
- rsp_data  out  WIDTH  pop data for the responding requester; 0 for push or error.
- rsp_err  out  1  set with rsp_valid when the op was rejected (push when full, pop when empty).
- flush  in  1  request to drain the stack.
- busy  out  1  high while in FLUSH.
- flush_done  out  1  one-cycle pulse when a flush completes.
- count  out  SIZE+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_data_in  out  WIDTH  to stack data_in.
- stk_data_out  in  WIDTH  from stack data_out.

Behaviour:
- Reset values:
  - state = RUN, rr_ptr = 0 (requester 0 has priority), count = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0, flush_done = 0.
  - stk_push = 0, stk_pop = 0.
  - Reset is effective at any time, including mid-flush.
  - The controller must be reset together with the stack; count and the stack pointer must stay consistent.
- FSM states: RUN, FLUSH.
- RUN, arbitration:
  - Combinational.
  - If flush = 1, no grant is issued this cycle.
  - Otherwise, if both req_valid bits are set, the requester indexed by rr_ptr wins; if one is set, that requester wins.
  - req_ready[w] = 1 only for the winner w.
  - After any accepted request, rr_ptr <= ~w.
  - rr_ptr holds when there is no grant.
- Accepted push:
  - If !full: stk_push = 1, stk_data_in = req_data[w], count +1.
  - If full: stack untouched, rsp_err = 1 next cycle.
- Accepted pop:
  - If !empty: stk_pop = 1, rsp_data <= stk_data_out (sampled in the grant cycle), count −1.
  - If empty: stack untouched, rsp_err = 1 and rsp_data = 0 next cycle.
- Response timing:
  - Latency is exactly 1 cycle: rsp_valid[w] is high the cycle after acceptance.
  - Responses are never back-pressured.
  - Back-to-back accepts produce back-to-back responses.
- stk_push and stk_pop are never high together; both are 0 when there is no grant.
- Flush entry (RUN, flush = 1):
  - If count != 0: next state is FLUSH.
  - If count == 0: stay in RUN and pulse flush_done the next cycle.
- FLUSH:
  - busy = 1, req_ready = 0.
  - stk_pop = 1 every cycle, count −1 per cycle; popped data is discarded.
  - On the cycle count goes 1→0, next state is RUN and flush_done pulses the following cycle.
  - The flush input is ignored while in FLUSH.
  - A flush of N entries takes N cycles.
- full and empty are decoded from the count register, so they reflect the post-edge occupancy.

Optional Feature:
- Macro: STACK_ARB_STATS_EN.
- When defined:
  - Adds outputs ovf_cnt[15:0] and unf_cnt[15:0].
  - ovf_cnt increments on each rejected push; unf_cnt increments on each rejected pop.
  - Both saturate at 16'hFFFF and clear only on reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan (WIDTH = 18, SIZE = 2, DEPTH = 4):
1. Reset release, then req0 pushes 18'h15555, then req0 pops → push rsp (err = 0, data = 0); pop rsp one cycle after acceptance with rsp_data = 18'h15555; count goes 0→1→0.
2. Both requesters valid with push every cycle (req0 data 18'h00001, req1 data 18'h00002) → grants alternate 0,1,0,1; count reaches 4 and full = 1; the fifth push is accepted with rsp_err = 1 and count stays 4; stack contents unchanged (verified by popping 2,1,2,1).
3. Pop on an empty stack → rsp_err = 1, rsp_data = 0, stk_pop never asserted, count stays 0; with the macro defined, unf_cnt = 1.
4. Push 3 entries, assert flush for one cycle → busy high for 3 cycles, stk_pop high for 3 cycles, req_ready = 0 throughout; flush_done pulses once; count = 0, empty = 1.
5. flush with count == 0 → no stk_pop; flush_done pulses the next cycle; busy stays 0.
6. Assert reset mid-flush (count = 2) → all outputs return to reset values asynchronously; after release, state = RUN and requester 0 wins the first simultaneous request.
